// File: rtl/scope_capture_if.sv
// Sample stream from the capture front end to the display line buffers.
//   sample : emitted sample value
//   valid  : sample valid, one cycle per sample
//   last   : marks record index RECORD_LEN-1
//   full   : display buffer holds an unconsumed record (sink -> source)
// master: the capture side (drives sample/valid/last, observes full).
// slave : the display side (observes the stream, drives full).
interface scope_capture_if #(
    parameter int unsigned DATA_W = 9
) ();
    logic [DATA_W-1:0] sample;
    logic              valid;
    logic              last;
    logic              full;

    modport master (output sample, output valid, output last, input full);
    modport slave  (input sample, input valid, input last, output full);
endinterface

// File: rtl/scope_capture.sv
// Acquisition front end for the waveform display. Decimates the ADC stream,
// keeps a PRE-deep pretrigger delay line, detects a level/edge trigger (with
// force and auto-timeout) and emits RECORD_LEN samples per capture, then waits
// for the display's full/empty handshake before re-arming.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   enable_i       : level; low forces IDLE
//   single_mode_i  : stop after one record until enable toggles
//   auto_en_i      : enable auto-trigger after AUTO_TO accepted samples
//   force_trig_i   : pulse; trigger on next accepted sample while ARMED
//   decim_i        : keep one of every decim_i+1 ADC strobes
//   trig_level_i   : unsigned trigger threshold
//   rising_i       : 1 rising-edge, 0 falling-edge trigger
//   adc_data_i     : raw ADC sample
//   adc_strobe_i   : adc_data_i valid this cycle
//   out_if         : sample/valid/last stream and full handshake
//   triggered_o    : high from trigger until record end
//   busy_o         : state is not IDLE
module scope_capture #(
    parameter int unsigned DATA_W     = 9,
    parameter int unsigned RECORD_LEN = 640,
    parameter int unsigned PRE        = 64,
    parameter int unsigned AUTO_TO    = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable_i,
    input  logic                single_mode_i,
    input  logic                auto_en_i,
    input  logic                force_trig_i,
    input  logic [7:0]          decim_i,
    input  logic [DATA_W-1:0]   trig_level_i,
    input  logic                rising_i,
    input  logic [DATA_W-1:0]   adc_data_i,
    input  logic                adc_strobe_i,
    scope_capture_if.master     out_if,
    output logic                triggered_o,
    output logic                busy_o
);
    localparam int unsigned CntW  = $clog2(RECORD_LEN);
    localparam int unsigned AutoW = $clog2(AUTO_TO + 1);
    localparam int unsigned PtrW  = (PRE > 1) ? $clog2(PRE) : 1;

    typedef enum logic [2:0] {
        StIdle, StFill, StArmed, StCapture, StWaitFull, StWaitEmpty
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        dec_q, dec_d;
    logic [CntW-1:0]   cnt_q, cnt_d;     // fill count in FILL, record index in CAPTURE
    logic [PtrW-1:0]   ptr_q, ptr_d;
    logic [AutoW-1:0]  auto_q, auto_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic              pv_q, pv_d;
    logic              force_q, force_d;
    logic              done_q, done_d;   // single record finished; wait for enable low
    logic              trig_q, trig_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] sample_q;
    logic              dl_we;
    logic              acq, accept, hit_level, hit_trig;

    logic [DATA_W-1:0] mem_q [PRE];

    assign acq    = (state_q == StFill) || (state_q == StArmed) || (state_q == StCapture);
    assign accept = acq && adc_strobe_i && (dec_q == 8'd0);

    // The first sample after ARMED entry only loads prev (pv_q still low).
    assign hit_level = pv_q && (rising_i
        ? ((prev_q < trig_level_i) && (adc_data_i >= trig_level_i))
        : ((prev_q > trig_level_i) && (adc_data_i <= trig_level_i)));

    assign hit_trig = hit_level || force_q || force_trig_i
                      || (auto_en_i && (auto_q >= AutoW'(AUTO_TO - 1)));

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        auto_d  = auto_q;
        prev_d  = prev_q;
        pv_d    = pv_q;
        force_d = force_q;
        done_d  = done_q;
        trig_d  = trig_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        dl_we   = 1'b0;

        // Decimation counter only runs while acquiring, so it is zero on FILL entry.
        if (acq) begin
            if (adc_strobe_i) begin
                dec_d = (dec_q == decim_i) ? 8'd0 : dec_q + 8'd1;
            end
        end else begin
            dec_d = 8'd0;
        end

        if (accept) begin
            dl_we = 1'b1;
            ptr_d = (ptr_q == PtrW'(PRE - 1)) ? '0 : ptr_q + PtrW'(1);
        end

        unique case (state_q)
            StIdle: begin
                if (enable_i && !done_q) begin
                    state_d = StFill;
                    cnt_d   = '0;
                end
            end
            StFill: begin
                pv_d    = 1'b0;
                force_d = 1'b0;
                auto_d  = '0;
                if (accept) begin
                    if (cnt_q == CntW'(PRE - 1)) begin
                        cnt_d   = '0;
                        state_d = StArmed;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StArmed: begin
                if (force_trig_i) begin
                    force_d = 1'b1;
                end
                if (accept) begin
                    prev_d = adc_data_i;
                    pv_d   = 1'b1;
                    if (auto_q != AutoW'(AUTO_TO)) begin
                        auto_d = auto_q + AutoW'(1);
                    end
                    if (hit_trig) begin
                        valid_d = 1'b1;
                        trig_d  = 1'b1;
                        cnt_d   = CntW'(1);
                        state_d = StCapture;
                    end
                end
            end
            StCapture: begin
                if (accept) begin
                    valid_d = 1'b1;
                    if (cnt_q == CntW'(RECORD_LEN - 1)) begin
                        last_d  = 1'b1;
                        trig_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = StWaitFull;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            StWaitFull: begin
                if (out_if.full) begin
                    state_d = StWaitEmpty;
                end
            end
            StWaitEmpty: begin
                if (!out_if.full) begin
                    if (single_mode_i) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        state_d = StFill;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Disable aborts everything, including an in-flight emission.
        if (!enable_i) begin
            state_d = StIdle;
            done_d  = 1'b0;
            trig_d  = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            dec_q    <= '0;
            cnt_q    <= '0;
            ptr_q    <= '0;
            auto_q   <= '0;
            prev_q   <= '0;
            pv_q     <= 1'b0;
            force_q  <= 1'b0;
            done_q   <= 1'b0;
            trig_q   <= 1'b0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            sample_q <= '0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            auto_q  <= auto_d;
            prev_q  <= prev_d;
            pv_q    <= pv_d;
            force_q <= force_d;
            done_q  <= done_d;
            trig_q  <= trig_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            // Old-data read: the oldest entry leaves before this sample overwrites it.
            if (valid_d) begin
                sample_q <= mem_q[ptr_q];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (dl_we) begin
            mem_q[ptr_q] <= adc_data_i;
        end
    end

    assign out_if.sample = sample_q;
    assign out_if.valid  = valid_q;
    assign out_if.last   = last_q;
    assign triggered_o   = trig_q;
    assign busy_o        = (state_q != StIdle);
endmodule

// File: tb/tb_scope_capture.sv
// Self-checking bench for scope_capture. Stimulus streams are built up front;
// the reference model decimates them, locates the trigger by the triggering
// rules over the accepted-sample array and predicts each record's contents and
// the cycle of every valid.
module tb_scope_capture;
    localparam int DATA_W     = 9;
    localparam int RECORD_LEN = 640;
    localparam int PRE        = 64;
    localparam int AUTO_TO    = 4096;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable, single_mode, auto_en, force_trig, rising, adc_strobe;
    logic [7:0]        decim;
    logic [DATA_W-1:0] trig_level, adc_data;
    logic              triggered, busy;

    scope_capture_if #(.DATA_W(DATA_W)) sif ();

    scope_capture #(
        .DATA_W(DATA_W), .RECORD_LEN(RECORD_LEN), .PRE(PRE), .AUTO_TO(AUTO_TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable_i     (enable),
        .single_mode_i(single_mode),
        .auto_en_i    (auto_en),
        .force_trig_i (force_trig),
        .decim_i      (decim),
        .trig_level_i (trig_level),
        .rising_i     (rising),
        .adc_data_i   (adc_data),
        .adc_strobe_i (adc_strobe),
        .out_if       (sif),
        .triggered_o  (triggered),
        .busy_o       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int got[$], vcyc[$], lastidx[$];
    int stim[$], gaps[$], acc[$], scyc[$];
    int force_at, trig_bad, t_model;
    int n_checks = 0, n_errors = 0;
    int n0;

    always @(negedge clk) begin
        if (!reset && sif.valid) begin
            if (sif.last) lastidx.push_back(got.size());
            if (triggered !== (got.size() < RECORD_LEN - 1)) trig_bad++;
            got.push_back(int'(sif.sample));
            vcyc.push_back(cyc);
        end
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        adc_strobe = 1'b0;
        force_trig = 1'b0;
    endtask

    task automatic clear_queues();
        got.delete(); vcyc.delete(); lastidx.delete();
        stim.delete(); gaps.delete(); acc.delete(); scyc.delete();
        trig_bad = 0;
        force_at = -1;
    endtask

    task automatic begin_run(input int dcm, input int lvl, input bit rs, input bit ae,
                             input bit sm);
        @(posedge clk); #1;
        enable = 1'b0;
        repeat (2) idle_cycle();
        decim = 8'(dcm); trig_level = DATA_W'(lvl); rising = rs;
        auto_en = ae; single_mode = sm;
        clear_queues();
        enable = 1'b1;
        repeat (2) idle_cycle();
    endtask

    // Keep one of every decim+1 strobes, starting with the first.
    function automatic void build_acc();
        acc.delete();
        for (int k = 0; k < stim.size(); k++)
            if (k % (int'(decim) + 1) == 0) acc.push_back(stim[k]);
    endfunction

    function automatic int find_trig();
        int lvl;
        bit hit;
        lvl = int'(trig_level);
        for (int i = PRE; i < acc.size(); i++) begin
            hit = 1'b0;
            if (i > PRE)
                hit = rising ? (acc[i-1] < lvl && acc[i] >= lvl)
                             : (acc[i-1] > lvl && acc[i] <= lvl);
            if (hit || (force_at >= 0 && i >= force_at) ||
                (auto_en && (i - PRE) >= AUTO_TO - 1))
                return i;
        end
        return -1;
    endfunction

    task automatic drive(input int stop_at, input bit kill_en, output int n_stop);
        int step;
        n_stop = -1;
        step = int'(decim) + 1;
        build_acc();
        t_model = find_trig();
        for (int k = 0; k < stim.size(); k++) begin
            if (stop_at >= 0 && got.size() >= stop_at) begin
                n_stop = got.size();
                if (kill_en) enable = 1'b0;
                return;
            end
            repeat (gaps[k]) idle_cycle();
            if (force_at >= 0 && k == force_at * step) begin
                if (t_model == force_at) check_eq("no_valid_before_force", got.size(), 0);
                @(posedge clk); #1;
                adc_strobe = 1'b0;
                force_trig = 1'b1;
            end
            @(posedge clk); #1;
            adc_data   = DATA_W'(stim[k]);
            adc_strobe = 1'b1;
            force_trig = 1'b0;
            scyc.push_back(cyc);
        end
        repeat (6) idle_cycle();
    endtask

    task automatic check_record(input string tag);
        int nexp, dmis, tmis, step;
        step = int'(decim) + 1;
        nexp = (t_model < 0) ? 0 : (acc.size() - t_model);
        if (nexp > RECORD_LEN) nexp = RECORD_LEN;
        check_eq({tag, "_count"}, got.size(), nexp);
        dmis = 0; tmis = 0;
        for (int k = 0; k < got.size() && k < nexp; k++) begin
            if (got[k] != acc[t_model - PRE + k]) dmis++;
            if (vcyc[k] != scyc[(t_model + k) * step] + 1) tmis++;
        end
        check_eq({tag, "_data"}, dmis, 0);
        check_eq({tag, "_timing"}, tmis, 0);
        check_eq({tag, "_lastcnt"}, lastidx.size(), (nexp == RECORD_LEN) ? 1 : 0);
        if (lastidx.size() == 1) check_eq({tag, "_lastidx"}, lastidx[0], RECORD_LEN - 1);
        check_eq({tag, "_trigflag"}, trig_bad, 0);
        check_eq({tag, "_trig_after"}, int'(triggered), 0);
    endtask

    task automatic pulse_full();
        @(posedge clk); #1;
        sif.full = 1'b1;
        repeat (50) idle_cycle();
        sif.full = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        enable = 1'b0; single_mode = 1'b0; auto_en = 1'b0; force_trig = 1'b0;
        rising = 1'b1; adc_strobe = 1'b0; decim = '0; trig_level = '0; adc_data = '0;
        sif.full = 1'b0;
        force_at = -1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_valid", int'(sif.valid), 0);
        check_eq("rst_last", int'(sif.last), 0);
        check_eq("rst_sample", int'(sif.sample), 0);
        check_eq("rst_triggered", int'(triggered), 0);
        check_eq("rst_busy", int'(busy), 0);
        reset = 1'b0;

        // Rising ramp, continuous mode.
        begin_run(0, 256, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 900; k++) begin stim.push_back(k % 512); gaps.push_back(0); end
        drive(-1, 1'b0, n0);
        check_record("ramp");
        if (got.size() == RECORD_LEN) begin
            check_eq("ramp_idx0", got[0], 192);
            check_eq("ramp_idxpre", got[PRE], 256);
            check_eq("ramp_idxlast", got[RECORD_LEN-1], 319);
        end

        // Held in WAIT_FULL: strobes must produce nothing.
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            adc_data = DATA_W'($urandom_range(0, 511));
            adc_strobe = 1'b1;
        end
        idle_cycle();
        check_eq("waitfull_busy", int'(busy), 1);
        check_eq("waitfull_novalid", got.size(), RECORD_LEN);
        pulse_full();
        repeat (2) idle_cycle();
        clear_queues();
        for (int k = 0; k < 1300; k++) begin stim.push_back((k + 300) % 512); gaps.push_back(0); end
        drive(-1, 1'b0, n0);
        check_record("rearm");

        // Falling square wave.
        begin_run(0, 256, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 900; k++) begin
            stim.push_back(((k / 16) % 2 == 0) ? 100 : 400); gaps.push_back(0);
        end
        drive(-1, 1'b0, n0);
        check_record("square");
        if (got.size() == RECORD_LEN) check_eq("square_idxpre", got[PRE], 100);

        // Auto trigger on a flat input.
        begin_run(0, 256, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < PRE + AUTO_TO + RECORD_LEN + 20; k++) begin
            stim.push_back(200); gaps.push_back(0);
        end
        drive(-1, 1'b0, n0);
        check_record("auto");
        if (got.size() > 0) check_eq("auto_start", vcyc[0], scyc[PRE + AUTO_TO - 1] + 1);

        // No auto: nothing for 10000 samples, then a forced trigger.
        begin_run(0, 256, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < PRE + 10000 + 700; k++) begin stim.push_back(200); gaps.push_back(0); end
        force_at = PRE + 10000;
        drive(-1, 1'b0, n0);
        check_record("force");

        // Decimation by 4.
        begin_run(3, 256, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 3700; k++) begin stim.push_back(k % 512); gaps.push_back(0); end
        drive(-1, 1'b0, n0);
        check_record("decim");
        if (got.size() == RECORD_LEN) begin
            check_eq("decim_spacing", vcyc[1] - vcyc[0], 4);
            check_eq("decim_span", vcyc[RECORD_LEN-1] - vcyc[0], (RECORD_LEN - 1) * 4);
        end

        // Single mode: stop in IDLE until enable toggles.
        begin_run(0, 256, 1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 900; k++) begin stim.push_back(k % 512); gaps.push_back(0); end
        drive(-1, 1'b0, n0);
        check_record("single");
        pulse_full();
        repeat (3) idle_cycle();
        check_eq("single_idle_busy", int'(busy), 0);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            adc_data = DATA_W'(k % 512);
            adc_strobe = 1'b1;
        end
        repeat (3) idle_cycle();
        check_eq("single_stays_idle", int'(busy), 0);
        check_eq("single_no_valid", got.size(), RECORD_LEN);
        enable = 1'b0;
        repeat (2) idle_cycle();
        enable = 1'b1;
        repeat (2) idle_cycle();
        check_eq("single_rearm_busy", int'(busy), 1);

        // Abort by dropping enable mid-capture.
        begin_run(0, 256, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 900; k++) begin stim.push_back(k % 512); gaps.push_back(0); end
        drive(300, 1'b1, n0);
        repeat (4) idle_cycle();
        check_eq("abort_busy", int'(busy), 0);
        check_eq("abort_triggered", int'(triggered), 0);
        check_eq("abort_nolast", lastidx.size(), 0);
        check_eq("abort_nvalid_ok", int'(n0 >= 300 && got.size() <= n0 + 1), 1);
        begin
            int dmis = 0;
            for (int k = 0; k < got.size(); k++)
                if (got[k] != acc[t_model - PRE + k]) dmis++;
            check_eq("abort_data", dmis, 0);
        end

        // Asynchronous reset mid-capture.
        begin_run(0, 256, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 900; k++) begin stim.push_back(k % 512); gaps.push_back(0); end
        drive(200, 1'b0, n0);
        @(posedge clk); #2;
        check_eq("prereset_triggered", int'(triggered), 1);
        reset = 1'b1;
        #1;
        check_eq("areset_valid", int'(sif.valid), 0);
        check_eq("areset_last", int'(sif.last), 0);
        check_eq("areset_sample", int'(sif.sample), 0);
        check_eq("areset_triggered", int'(triggered), 0);
        check_eq("areset_busy", int'(busy), 0);
        idle_cycle();
        reset = 1'b0;
        repeat (2) idle_cycle();
        clear_queues();
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            adc_data = DATA_W'(200);
            adc_strobe = 1'b1;
        end
        repeat (3) idle_cycle();
        check_eq("post_reset_novalid", got.size(), 0);

        // Randomised records.
        for (int r = 0; r < 4; r++) begin
            int dcm;
            dcm = $urandom_range(0, 3);
            begin_run(dcm, $urandom_range(50, 450), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
            for (int k = 0; k < (PRE + RECORD_LEN + 200) * (dcm + 1); k++) begin
                stim.push_back($urandom_range(0, 511));
                gaps.push_back(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            end
            if ($urandom_range(0, 1) == 1) force_at = PRE + $urandom_range(0, 20);
            drive(-1, 1'b0, n0);
            check_record($sformatf("rand%0d", r));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
